// File: rtl/ucsbece154b_icache_lru.sv
`timescale 1ns/1ps
// ucsbece154b_icache_lru
// Set-associative instruction cache placed between instruction fetch and the
// SDRAM controller. Replacement is true LRU, tracked with one age counter per
// line. A miss refills the whole block as a wrapping burst that starts at the
// critical word. With CRITICAL_FIRST set, the fetch is answered as soon as that
// first word arrives. Flush invalidates every line in a single cycle.
//
// Ports
//   Clk, Reset              rising-edge clock, synchronous active-high reset
//   ReadEnable, ReadAddress fetch request (accepted only in IDLE)
//   Flush                   invalidate all lines (accepted only in IDLE)
//   Instruction, Ready      fetched word plus a one-cycle valid pulse
//   Busy                    a refill is in progress
//   MemReadAddress          word-aligned address of the critical word
//   MemReadRequest          refill request, held until the last beat
//   MemDataIn, MemDataReady refill beat data and its strobe
module ucsbece154b_icache_lru #(
  parameter int NUM_SETS       = 8,
  parameter int NUM_WAYS       = 4,
  parameter int BLOCK_WORDS    = 4,
  parameter int WORD_SIZE      = 32,
  parameter int CRITICAL_FIRST = 1
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 ReadEnable,
  input  logic [31:0]          ReadAddress,
  input  logic                 Flush,
  output logic [WORD_SIZE-1:0] Instruction,
  output logic                 Ready,
  output logic                 Busy,
  output logic [31:0]          MemReadAddress,
  output logic                 MemReadRequest,
  input  logic [31:0]          MemDataIn,
  input  logic                 MemDataReady
);

  localparam int OFFW = $clog2(BLOCK_WORDS);
  localparam int SETW = $clog2(NUM_SETS);
  localparam int WAYW = $clog2(NUM_WAYS);
  localparam int TAGW = 30 - OFFW - SETW;

  typedef enum logic [1:0] {IDLE, LOOKUP, REFILL} stateT;

  stateT stateQ;
  logic [29:0]     reqAddrQ;
  logic [OFFW-1:0] beatQ;
  logic [OFFW-1:0] beatD;
  logic [WAYW-1:0] victimQ;

  logic                 validQ [NUM_SETS][NUM_WAYS];
  logic [TAGW-1:0]      tagQ   [NUM_SETS][NUM_WAYS];
  logic [WAYW-1:0]      ageQ   [NUM_SETS][NUM_WAYS];
  logic [WORD_SIZE-1:0] dataQ  [NUM_SETS][NUM_WAYS][BLOCK_WORDS];

  logic [OFFW-1:0] reqOffset;
  logic [SETW-1:0] reqSet;
  logic [TAGW-1:0] reqTag;
  logic [OFFW-1:0] fillWord;
  logic            lastBeat;
  logic            beatAccepted;

  logic            hit;
  logic [WAYW-1:0] hitWay;
  logic            foundFree;
  logic [WAYW-1:0] victimWay;
  logic            lruEnable;
  logic [WAYW-1:0] lruWay;

  // Byte-offset bits of the fetch address never select anything
  logic unusedAddrBits;
  assign unusedAddrBits = ^ReadAddress[1:0];

  assign reqOffset = reqAddrQ[OFFW-1:0];
  assign reqSet    = reqAddrQ[OFFW+SETW-1:OFFW];
  assign reqTag    = reqAddrQ[29:OFFW+SETW];

  // The burst wraps around the block, so beat i lands at offset+i modulo
  // block size; the narrow adder supplies the wrap for free
  assign fillWord     = reqOffset + beatQ;
  assign beatD        = beatQ + OFFW'(1);
  assign lastBeat     = (beatQ == OFFW'(BLOCK_WORDS - 1));
  assign beatAccepted = (stateQ == REFILL) && MemDataReady;

  // Tag compare across all ways of the addressed set
  always_comb begin
    hit    = 1'b0;
    hitWay = '0;
    for (int k = 0; k < NUM_WAYS; k++) begin
      if (!hit && validQ[reqSet][k] && (tagQ[reqSet][k] == reqTag)) begin
        hit    = 1'b1;
        hitWay = WAYW'(k);
      end
    end
  end

  // Victim: lowest free way first, otherwise the way that has aged out
  always_comb begin
    foundFree = 1'b0;
    victimWay = '0;
    for (int k = 0; k < NUM_WAYS; k++) begin
      if (!foundFree && !validQ[reqSet][k]) begin
        foundFree = 1'b1;
        victimWay = WAYW'(k);
      end
    end
    if (!foundFree) begin
      for (int k = 0; k < NUM_WAYS; k++) begin
        if (ageQ[reqSet][k] == WAYW'(NUM_WAYS - 1)) begin
          victimWay = WAYW'(k);
        end
      end
    end
  end

  // A line becomes most recently used on a lookup hit or on a completed fill
  always_comb begin
    lruEnable = 1'b0;
    lruWay    = victimQ;
    if (stateQ == LOOKUP && hit) begin
      lruEnable = 1'b1;
      lruWay    = hitWay;
    end else if (beatAccepted && lastBeat) begin
      lruEnable = 1'b1;
    end
  end

  // Tag and data arrays carry no reset; reset only drops the valid bits.
  // Beats that arrive in the same cycle as reset are not written.
  always_ff @(posedge Clk) begin
    if (!Reset && beatAccepted) begin
      dataQ[reqSet][victimQ][fillWord] <= WORD_SIZE'(MemDataIn);
      if (lastBeat) begin
        tagQ[reqSet][victimQ] <= reqTag;
      end
    end
  end

  // Controller: FSM, registered outputs, valid bits and LRU ages
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stateQ         <= IDLE;
      reqAddrQ       <= '0;
      beatQ          <= '0;
      victimQ        <= '0;
      Instruction    <= '0;
      Ready          <= 1'b0;
      Busy           <= 1'b0;
      MemReadRequest <= 1'b0;
      MemReadAddress <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int k = 0; k < NUM_WAYS; k++) begin
          validQ[s][k] <= 1'b0;
          ageQ[s][k]   <= WAYW'(k);
        end
      end
    end else begin
      Ready <= 1'b0;
      case (stateQ)
        IDLE: begin
          // Flush takes priority and swallows a simultaneous fetch
          if (Flush) begin
            for (int s = 0; s < NUM_SETS; s++) begin
              for (int k = 0; k < NUM_WAYS; k++) begin
                validQ[s][k] <= 1'b0;
              end
            end
          end else if (ReadEnable) begin
            reqAddrQ <= ReadAddress[31:2];
            stateQ   <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            Ready       <= 1'b1;
            Instruction <= dataQ[reqSet][hitWay][reqOffset];
            stateQ      <= IDLE;
          end else begin
            victimQ        <= victimWay;
            beatQ          <= '0;
            MemReadAddress <= {reqAddrQ, 2'b00};
            MemReadRequest <= 1'b1;
            Busy           <= 1'b1;
            stateQ         <= REFILL;
          end
        end
        REFILL: begin
          if (MemDataReady) begin
            beatQ <= beatD;
            // Early restart: the first beat is always the critical word
            if (CRITICAL_FIRST != 0 && beatQ == '0) begin
              Ready       <= 1'b1;
              Instruction <= WORD_SIZE'(MemDataIn);
            end
            if (lastBeat) begin
              validQ[reqSet][victimQ] <= 1'b1;
              MemReadRequest          <= 1'b0;
              Busy                    <= 1'b0;
              stateQ                  <= IDLE;
              // The critical word was stored on beat 0, so it is already
              // sitting in the data array by the time the last beat lands
              if (CRITICAL_FIRST == 0) begin
                Ready       <= 1'b1;
                Instruction <= dataQ[reqSet][victimQ][reqOffset];
              end
            end
          end
        end
        default: stateQ <= IDLE;
      endcase

      if (lruEnable) begin
        for (int k = 0; k < NUM_WAYS; k++) begin
          if (WAYW'(k) == lruWay) begin
            ageQ[reqSet][k] <= '0;
          end else if (validQ[reqSet][k] &&
                       (ageQ[reqSet][k] < ageQ[reqSet][lruWay])) begin
            ageQ[reqSet][k] <= ageQ[reqSet][k] + WAYW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ucsbece154b_icache_lru.sv
`timescale 1ns/1ps
// Testbench for ucsbece154b_icache_lru. Two instances share one stimulus
// stream: one with early restart on the critical word and one without.
// A cache model inside the bench predicts the outputs of both instances
// every cycle, and literal expectations for the key scenarios pin down the
// model itself.
module tb_ucsbece154b_icache_lru;

  localparam int NS = 8;
  localparam int NW = 4;
  localparam int BW = 4;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        ReadEnable = 1'b0;
  logic [31:0] ReadAddress = '0;
  logic        Flush = 1'b0;
  logic [31:0] MemDataIn = '0;
  logic        MemDataReady = 1'b0;

  logic [31:0] instrC, instrN, addrC, addrN;
  logic        rdyC, rdyN, busyC, busyN, reqC, reqN;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  ucsbece154b_icache_lru #(.NUM_SETS(NS), .NUM_WAYS(NW), .BLOCK_WORDS(BW),
                           .WORD_SIZE(32), .CRITICAL_FIRST(1)) dutCrit (
    .Clk(clk), .Reset(Reset), .ReadEnable(ReadEnable), .ReadAddress(ReadAddress),
    .Flush(Flush), .Instruction(instrC), .Ready(rdyC), .Busy(busyC),
    .MemReadAddress(addrC), .MemReadRequest(reqC), .MemDataIn(MemDataIn),
    .MemDataReady(MemDataReady));

  ucsbece154b_icache_lru #(.NUM_SETS(NS), .NUM_WAYS(NW), .BLOCK_WORDS(BW),
                           .WORD_SIZE(32), .CRITICAL_FIRST(0)) dutFull (
    .Clk(clk), .Reset(Reset), .ReadEnable(ReadEnable), .ReadAddress(ReadAddress),
    .Flush(Flush), .Instruction(instrN), .Ready(rdyN), .Busy(busyN),
    .MemReadAddress(addrN), .MemReadRequest(reqN), .MemDataIn(MemDataIn),
    .MemDataReady(MemDataReady));

  // Every comparison funnels through here so the counters stay honest
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      if (mismatched <= 40)
        $display("[TB] FAIL %s: got 0x%h, expected 0x%h at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Lines are plain arrays; address fields come from division and modulo.
  // Index 1 of the ready/instruction expectations is the early-restart
  // instance, index 0 the full-block instance.
  bit          mValid [NS][NW];
  logic [31:0] mTag   [NS][NW];
  int          mAge   [NS][NW];
  logic [31:0] mData  [NS][NW][BW];
  bit          modelLive = 0;
  int          mPhase;
  logic [31:0] mAddr;
  int          mVictim, mBeat, mSet, mOff, mHitWay;
  logic [31:0] mTagNow, mCrit;
  logic        mReady [2];
  logic [31:0] mInstr [2];
  logic        mBusy, mReq;
  logic [31:0] mMemAddr;

  task automatic mTouch(input int s, input int w);
    int old;
    old = mAge[s][w];
    for (int k = 0; k < NW; k++)
      if (k != w && mValid[s][k] && mAge[s][k] < old) mAge[s][k]++;
    mAge[s][w] = 0;
  endtask

  always @(posedge clk) begin
    if (Reset) begin
      modelLive = 1;
      mPhase = 0; mBusy = 0; mReq = 0; mMemAddr = 0;
      for (int i = 0; i < 2; i++) begin mReady[i] = 0; mInstr[i] = 0; end
      for (int s = 0; s < NS; s++)
        for (int k = 0; k < NW; k++) begin mValid[s][k] = 0; mAge[s][k] = k; end
    end else if (modelLive) begin
      mReady[0] = 0; mReady[1] = 0;
      mOff    = int'((mAddr / 4) % BW);
      mSet    = int'((mAddr / (4 * BW)) % NS);
      mTagNow = mAddr / (4 * BW * NS);
      case (mPhase)
        0: begin
          if (Flush) begin
            for (int s = 0; s < NS; s++)
              for (int k = 0; k < NW; k++) mValid[s][k] = 0;
          end else if (ReadEnable) begin
            mAddr = ReadAddress; mPhase = 1;
          end
        end
        1: begin
          mHitWay = -1;
          for (int k = NW - 1; k >= 0; k--)
            if (mValid[mSet][k] && mTag[mSet][k] == mTagNow) mHitWay = k;
          if (mHitWay >= 0) begin
            mReady[0] = 1; mReady[1] = 1;
            mInstr[0] = mData[mSet][mHitWay][mOff];
            mInstr[1] = mData[mSet][mHitWay][mOff];
            mTouch(mSet, mHitWay);
            mPhase = 0;
          end else begin
            mVictim = -1;
            for (int k = NW - 1; k >= 0; k--)
              if (!mValid[mSet][k]) mVictim = k;
            if (mVictim < 0)
              for (int k = 0; k < NW; k++)
                if (mAge[mSet][k] == NW - 1) mVictim = k;
            if (mVictim < 0) mVictim = 0;
            mMemAddr = {mAddr[31:2], 2'b00};
            mReq = 1; mBusy = 1; mBeat = 0; mPhase = 2;
          end
        end
        default: begin
          if (MemDataReady) begin
            mData[mSet][mVictim][(mOff + mBeat) % BW] = MemDataIn;
            if (mBeat == 0) begin
              mCrit = MemDataIn; mReady[1] = 1; mInstr[1] = MemDataIn;
            end
            mBeat++;
            if (mBeat == BW) begin
              mTouch(mSet, mVictim);
              mValid[mSet][mVictim] = 1;
              mTag[mSet][mVictim] = mTagNow;
              mReq = 0; mBusy = 0;
              mReady[0] = 1; mInstr[0] = mCrit;
              mPhase = 0;
            end
          end
        end
      endcase
    end
  end

  // Compare both instances against the model on every falling edge
  always @(negedge clk) begin
    if (modelLive) begin
      checkOutput("readyCrit", 32'(rdyC), 32'(mReady[1]));
      checkOutput("instrCrit", instrC, mInstr[1]);
      checkOutput("busyCrit", 32'(busyC), 32'(mBusy));
      checkOutput("reqCrit", 32'(reqC), 32'(mReq));
      checkOutput("memAddrCrit", addrC, mMemAddr);
      checkOutput("readyFull", 32'(rdyN), 32'(mReady[0]));
      checkOutput("instrFull", instrN, mInstr[0]);
      checkOutput("busyFull", 32'(busyN), 32'(mBusy));
      checkOutput("reqFull", 32'(reqN), 32'(mReq));
      checkOutput("memAddrFull", addrN, mMemAddr);
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] beatBuf [BW];

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  // Beat data in wrap order, starting at the critical word of addr
  task automatic loadBlock(input logic [31:0] addr);
    logic [31:0] base;
    int off;
    base = addr & ~32'(BW * 4 - 1);
    off  = int'((addr / 4) % BW);
    for (int i = 0; i < BW; i++) beatBuf[i] = memWord(base + 32'(((off + i) % BW) * 4));
  endtask

  // One-cycle request/flush pulse; returns #1 after the LOOKUP edge
  task automatic applyStimulus(input logic [31:0] addr, input bit flush, input bit rd);
    ReadAddress = addr; Flush = flush; ReadEnable = rd;
    @(posedge clk); #1;
    ReadEnable = 0; Flush = 0;
    @(posedge clk); #1;
  endtask

  // Delivers nBeats beats from beatBuf with gap idle cycles before each
  task automatic serveRefill(input int nBeats, input int gap);
    for (int i = 0; i < nBeats; i++) begin
      repeat (gap) begin @(posedge clk); #1; end
      MemDataIn = beatBuf[i]; MemDataReady = 1;
      @(posedge clk); #1;
      MemDataReady = 0;
      checkOutput("earlyRestartPulse", 32'(rdyC), (i == 0) ? 32'd1 : 32'd0);
      checkOutput("fullBlockPulse", 32'(rdyN), (i == BW - 1) ? 32'd1 : 32'd0);
      if (i == 0) checkOutput("earlyRestartWord", instrC, beatBuf[0]);
      if (i == BW - 1) checkOutput("fullBlockWord", instrN, beatBuf[0]);
    end
  endtask

  task automatic readHit(input logic [31:0] addr, input logic [31:0] expected);
    applyStimulus(addr, 0, 1);
    checkOutput("hitReadyCrit", 32'(rdyC), 32'd1);
    checkOutput("hitReadyFull", 32'(rdyN), 32'd1);
    checkOutput("hitWordCrit", instrC, expected);
    checkOutput("hitWordFull", instrN, expected);
  endtask

  task automatic readMiss(input logic [31:0] addr);
    applyStimulus(addr, 0, 1);
    checkOutput("missRequest", 32'(reqC), 32'd1);
    checkOutput("missBusy", 32'(busyN), 32'd1);
    checkOutput("missAddress", addrC, {addr[31:2], 2'b00});
    loadBlock(addr);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 Reset = 0;
    checkOutput("resetReady", 32'(rdyC), 32'd0);
    checkOutput("resetBusy", 32'(busyC), 32'd0);
    checkOutput("resetReq", 32'(reqN), 32'd0);
    checkOutput("resetAddr", addrC, 32'd0);
    checkOutput("resetInstr", instrN, 32'd0);
    @(posedge clk); #1;

    // Cold miss with critical word at offset 2, gapped beats
    readMiss(32'h0000_0048);
    checkOutput("coldMissAddr", addrN, 32'h0000_0048);
    beatBuf[0] = 32'hA; beatBuf[1] = 32'hB; beatBuf[2] = 32'hC; beatBuf[3] = 32'hD;
    serveRefill(BW, 1);
    // Requested in the cycle Busy falls; offsets 0 and 1 got beats 2 and 3
    readHit(32'h0000_0040, 32'hC);
    readHit(32'h0000_0044, 32'hD);
    readHit(32'h0000_0048, 32'hA);

    // Fill all four ways of set 0, touch 0x000, then force an eviction
    readMiss(32'h000); serveRefill(BW, 0);
    readMiss(32'h080); serveRefill(BW, 0);
    readMiss(32'h100); serveRefill(BW, 2);
    readMiss(32'h180); serveRefill(BW, 0);
    readHit(32'h000, 32'hC0DE_0000);
    readMiss(32'h200); serveRefill(BW, 0);
    readHit(32'h000, 32'hC0DE_0000);
    readHit(32'h104, 32'hC0DE_0104);
    readMiss(32'h080); serveRefill(BW, 1);

    // Flush after a hit invalidates the line
    readHit(32'h000, 32'hC0DE_0000);
    applyStimulus(32'h0, 1, 0);
    readMiss(32'h000); serveRefill(BW, 0);

    // Reset in the middle of a refill, then a stray beat in IDLE
    readMiss(32'h048);
    serveRefill(3, 1);
    Reset = 1;
    @(posedge clk); #1;
    Reset = 0;
    checkOutput("midResetBusy", 32'(busyC), 32'd0);
    checkOutput("midResetReq", 32'(reqN), 32'd0);
    MemDataIn = 32'hDEAD_BEEF; MemDataReady = 1;
    @(posedge clk); #1;
    MemDataReady = 0;
    checkOutput("strayBeatReady", 32'(rdyC), 32'd0);
    readMiss(32'h048); serveRefill(BW, 0);

    // Flush together with ReadEnable: request dropped, cache emptied
    applyStimulus(32'h048, 1, 1);
    checkOutput("flushReadReady", 32'(rdyC), 32'd0);
    checkOutput("flushReadBusy", 32'(busyN), 32'd0);
    @(posedge clk); #1;
    checkOutput("flushReadLate", 32'(rdyN), 32'd0);
    readMiss(32'h048); serveRefill(BW, 0);

    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
